// File: rtl/display_driver_iceqman.sv
// display_driver_iceqman
// Four-digit multiplexed seven-segment driver. Each digit is lit for
// REFRESH_DIV cycles in turn: digit 0, 1, 2, 3, then back to 0. A load
// strobe captures a 16-bit word for display.
//
// Build option: define DISPLAY_DECIMAL_EN to show the word in decimal.
// A double-dabble engine then converts it over 17 cycles, holding busy high.
// Values above 9999 show as four dashes. Without the macro the word is
// shown in hex, is written on the load edge, and busy stays low.
module display_driver_iceqman #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        busy
);

  // Last count before the scan moves to the next digit.
  // With REFRESH_DIV=1 this is 0, so the digit index advances every cycle.
  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dash_q, dash_d;
  logic [3:0]  cur_digit;

  // Refresh timer and digit index.
  // These are never touched by a load, so new digits show on the lit digit.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (cnt_q == DIV_LAST) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end
  end

`ifdef DISPLAY_DECIMAL_EN

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] bcd_adj;
  logic [3:0]  iter_q, iter_d;
  logic        busy_q, busy_d;

  // Double-dabble correction: add 3 to each BCD nibble of 5 or more.
  // This runs before the shift so the nibble carries correctly into the next decade.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 5; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) begin
        bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM. The display registers change only in DONE, so an
  // aborted or ignored conversion never leaves partial digits.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    busy_d   = busy_q;
    digits_d = digits_q;
    dash_d   = dash_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d = value;
          bcd_d   = 20'd0;
          iter_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bcd_q[19:16] != 4'd0) begin
          dash_d = 4'hF;
        end else begin
          digits_d = bcd_q[15:0];
          dash_d   = 4'h0;
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Conversion registers. A reset abandons any conversion in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= 16'd0;
      bcd_q   <= 20'd0;
      iter_q  <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

`else

  // Hex capture. A load writes all four nibbles directly, since the driver is never busy.
  always_comb begin
    digits_d = digits_q;
    dash_d   = dash_q;
    if (load) begin
      digits_d = value;
      dash_d   = 4'h0;
    end
  end

  assign busy = 1'b0;

`endif

  // Scan position and displayed digits.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= 16'd0;
      idx_q    <= 2'd0;
      digits_q <= 16'd0;
      dash_q   <= 4'h0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      dash_q   <= dash_d;
    end
  end

  // Active-low anode select: only the digit being scanned is driven low.
  always_comb begin
    anode        = 4'b1111;
    anode[idx_q] = 1'b0;
  end

  // Glyph decode for the lit digit, active-low, ordered {g,f,e,d,c,b,a}.
  always_comb begin
    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    case (cur_digit)
      4'h0:    segments = 7'b1000000;
      4'h1:    segments = 7'b1111001;
      4'h2:    segments = 7'b0100100;
      4'h3:    segments = 7'b0110000;
      4'h4:    segments = 7'b0011001;
      4'h5:    segments = 7'b0010010;
      4'h6:    segments = 7'b0000010;
      4'h7:    segments = 7'b1111000;
      4'h8:    segments = 7'b0000000;
      4'h9:    segments = 7'b0010000;
      4'hA:    segments = 7'b0001000;
      4'hB:    segments = 7'b0000011;
      4'hC:    segments = 7'b1000110;
      4'hD:    segments = 7'b0100001;
      4'hE:    segments = 7'b0000110;
      default: segments = 7'b0001110;
    endcase
    if (dash_q[idx_q]) begin
      segments = 7'b0111111;
    end
  end

endmodule

// File: tb/tb_display_driver_iceqman.sv
// Testbench for display_driver_iceqman.
// It drives two instances from the same inputs: REFRESH_DIV=4 and REFRESH_DIV=1.
// The fast-scan instance shows all four digits within four cycles.
// Expected displays come from the value using decimal or hex arithmetic,
// matching the DISPLAY_DECIMAL_EN build setting.
module tb_display_driver_iceqman;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] value = 16'd0;
  logic [3:0]  anode, anode1;
  logic [6:0]  segments, segments1;
  logic        busy, busy1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_dig [4];
  bit exp_dash = 1'b0;

`ifdef DISPLAY_DECIMAL_EN
  localparam int EXP_BUSY = 17;
`else
  localparam int EXP_BUSY = 0;
`endif

  always #5 clock = ~clock;

  display_driver_iceqman #(.REFRESH_DIV(4)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .anode(anode), .segments(segments), .busy(busy)
  );

  display_driver_iceqman #(.REFRESH_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .anode(anode1), .segments(segments1), .busy(busy1)
  );

  // Count of clock cycles since the last reset edge
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] glyph(input int d, input bit dash);
    if (dash) return 7'b0111111;
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] anode_for(input int idx);
    logic [3:0] a;
    a = 4'b1111;
    a[idx] = 1'b0;
    return a;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) exp_dig[i] = 0;
    exp_dash = 1'b0;
  endfunction

  function automatic void model_load(input logic [15:0] v);
    int t;
    t = int'(v);
`ifdef DISPLAY_DECIMAL_EN
    if (t > 9999) begin
      exp_dash = 1'b1;
    end else begin
      exp_dash = 1'b0;
      for (int i = 0; i < 4; i++) begin
        exp_dig[i] = t % 10;
        t = t / 10;
      end
    end
`else
    exp_dash = 1'b0;
    for (int i = 0; i < 4; i++) exp_dig[i] = (t >> (4 * i)) & 15;
`endif
  endfunction

  // Pulse load for one edge, then wait out busy (bounded) and count its cycles
  task automatic apply_load(input logic [15:0] v, output int busy_cycles);
    @(negedge clock);
    value = v;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clock);
    end
    model_load(v);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    vectors++;
    if (anode !== 4'b1110 || segments !== 7'b1000000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got anode=%b seg=%b busy=%b, want 1110 1000000 0", anode, segments, busy);
    end
    vectors++;
    if (busy1 !== 1'b0 || segments1 !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_div1: got seg=%b busy=%b, want 1000000 0", segments1, busy1);
    end
  endtask

  task automatic test_scan();
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      vectors++;
      if (anode !== anode_for((cyc / 4) % 4)) begin
        miscompares++;
        $display("FAIL scan_div4 cyc=%0d: got anode=%b, want %b", cyc, anode, anode_for((cyc / 4) % 4));
      end
      vectors++;
      if (anode1 !== anode_for(cyc % 4)) begin
        miscompares++;
        $display("FAIL scan_div1 cyc=%0d: got anode=%b, want %b", cyc, anode1, anode_for(cyc % 4));
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] vals [4];
    int bc;
`ifdef DISPLAY_DECIMAL_EN
    vals = '{16'd1234, 16'd10000, 16'hFFFF, 16'd9999};
`else
    vals = '{16'hA3F0, 16'h0000, 16'hFFFF, 16'h5A6C};
`endif
    foreach (vals[j]) begin
      apply_load(vals[j], bc);
      vectors++;
      if (bc !== EXP_BUSY) begin
        miscompares++;
        $display("FAIL directed_busy %h: got %0d busy cycles, want %0d", vals[j], bc, EXP_BUSY);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (anode1 !== anode_for(cyc % 4) || segments1 !== glyph(exp_dig[cyc % 4], exp_dash)) begin
          miscompares++;
          $display("FAIL directed %h digit%0d: got anode=%b seg=%b, want anode=%b seg=%b", vals[j], cyc % 4,
                   anode1, segments1, anode_for(cyc % 4), glyph(exp_dig[cyc % 4], exp_dash));
        end
        vectors++;
        if (segments !== glyph(exp_dig[(cyc / 4) % 4], exp_dash)) begin
          miscompares++;
          $display("FAIL directed_div4 %h: got seg=%b, want %b", vals[j], segments, glyph(exp_dig[(cyc / 4) % 4], exp_dash));
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int bc;
    for (int j = 0; j < 10; j++) begin
      v = (j % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      apply_load(v, bc);
      vectors++;
      if (bc !== EXP_BUSY) begin
        miscompares++;
        $display("FAIL random_busy %h: got %0d busy cycles, want %0d", v, bc, EXP_BUSY);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (anode1 !== anode_for(cyc % 4) || segments1 !== glyph(exp_dig[cyc % 4], exp_dash)) begin
          miscompares++;
          $display("FAIL random %h digit%0d: got anode=%b seg=%b, want anode=%b seg=%b", v, cyc % 4,
                   anode1, segments1, anode_for(cyc % 4), glyph(exp_dig[cyc % 4], exp_dash));
        end
        @(negedge clock);
      end
    end
  endtask

`ifdef DISPLAY_DECIMAL_EN
  // A second load three cycles into a conversion must be dropped
  task automatic test_back_to_back();
    int bc;
    @(negedge clock);
    value = 16'd5;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 40) begin
      if (bc == 2) begin
        value = 16'd7;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      bc++;
      @(negedge clock);
    end
    load = 1'b0;
    model_load(16'd5);
    vectors++;
    if (bc !== 17) begin
      miscompares++;
      $display("FAIL ignore_busy: got %0d busy cycles, want 17", bc);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (segments1 !== glyph(exp_dig[cyc % 4], exp_dash) || busy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_load digit%0d: got seg=%b busy=%b, want seg=%b busy=0", cyc % 4,
                 segments1, busy1, glyph(exp_dig[cyc % 4], exp_dash));
      end
      @(negedge clock);
    end
  endtask
`else
  // Loads on consecutive edges: each takes effect immediately, and the last one stays shown
  task automatic test_back_to_back();
    logic [15:0] v1, v2;
    v1 = 16'($urandom);
    v2 = 16'($urandom);
    @(negedge clock);
    value = v1;
    load  = 1'b1;
    @(negedge clock);
    model_load(v1);
    vectors++;
    if (segments1 !== glyph(exp_dig[cyc % 4], exp_dash)) begin
      miscompares++;
      $display("FAIL b2b_first %h: got seg=%b, want %b", v1, segments1, glyph(exp_dig[cyc % 4], exp_dash));
    end
    value = v2;
    @(negedge clock);
    load = 1'b0;
    model_load(v2);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (segments1 !== glyph(exp_dig[cyc % 4], exp_dash)) begin
        miscompares++;
        $display("FAIL b2b_second %h digit%0d: got seg=%b, want %b", v2, cyc % 4, segments1, glyph(exp_dig[cyc % 4], exp_dash));
      end
      @(negedge clock);
    end
  endtask
`endif

  task automatic test_reset_priority();
    int bc;
    apply_load(16'h4321, bc);
    @(negedge clock);
    reset = 1'b1;
    load  = 1'b1;
    value = 16'($urandom);
    @(negedge clock);
    reset = 1'b0;
    load  = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (anode1 !== anode_for(cyc % 4) || segments1 !== 7'b1000000 || busy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_priority k=%0d: got anode=%b seg=%b busy=%b, want %b 1000000 0", k,
                 anode1, segments1, busy1, anode_for(cyc % 4));
      end
      @(negedge clock);
    end
  endtask

`ifdef DISPLAY_DECIMAL_EN
  // Reset in the middle of a conversion leaves zeros, not a partial result
  task automatic test_abort();
    @(negedge clock);
    value = 16'd8765;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 24; k++) begin
      vectors++;
      if (segments1 !== glyph(exp_dig[cyc % 4], exp_dash) || busy1 !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort k=%0d: got seg=%b busy=%b/%b, want 1000000 0/0", k, segments1, busy1, busy);
      end
      @(negedge clock);
    end
  endtask
`endif

  initial begin
    $display("[TB] display_driver_iceqman bench start");
    test_reset();
    test_scan();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_priority();
`ifdef DISPLAY_DECIMAL_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
